// File: rtl/qam_mapper.sv
// Serial-bit to 802.11a constellation mapper (BPSK/QPSK/16-QAM/64-QAM, Gray coded).
// Define QAM_MAPPER_NORM_EN to scale levels by the per-modulation normalisation factor.
module qam_mapper #(
  parameter int unsigned OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    sync,
  input  logic                    in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic                    out_valid,
  output logic [5:0]              out_sc_idx,
  output logic                    out_last
);

  logic [2:0] bcnt_q, bcnt_d, bcnt_eff, last_idx;
  logic [5:0] sr_q, sr_d, sr_eff, bits;
  logic [5:0] sc_q, sc_d, sc_eff;
  logic [1:0] mode_q, mode_d, mode_eff;
  logic       done;

  logic signed [3:0]       lvl_i, lvl_q;
  logic signed [OUT_W-1:0] ext_i, ext_q, smp_i, smp_q;
  logic signed [OUT_W-1:0] i_q, i_d, q_q, q_d;
  logic                    valid_q, valid_d, last_q, last_d;
  logic [5:0]              idx_q, idx_d;

  function automatic logic signed [3:0] pam4(input logic first, input logic second);
    return second ? (first ? 4'sd1 : -4'sd1) : (first ? 4'sd3 : -4'sd3);
  endfunction

  function automatic logic signed [3:0] pam8(input logic first, input logic mid,
                                             input logic lst);
    logic signed [3:0] mag;
    unique case ({mid, lst})
      2'b00:   mag = 4'sd7;
      2'b01:   mag = 4'sd5;
      2'b11:   mag = 4'sd3;
      default: mag = 4'sd1;
    endcase
    return first ? mag : -mag;
  endfunction

  // sync acts on the same edge, so the accepted bit can already start a new group
  always_comb begin
    bcnt_eff = sync ? 3'd0 : bcnt_q;
    sr_eff   = sync ? 6'd0 : sr_q;
    sc_eff   = sync ? 6'd0 : sc_q;
    mode_eff = (bcnt_eff == 3'd0) ? mode : mode_q;
    bits     = sr_eff;
    for (int k = 0; k < 6; k++) begin
      if (bcnt_eff == 3'(k)) bits[k] = in;
    end
    unique case (mode_eff)
      2'b00:   last_idx = 3'd0;
      2'b01:   last_idx = 3'd1;
      2'b10:   last_idx = 3'd3;
      default: last_idx = 3'd5;
    endcase
    done = in_valid && (bcnt_eff == last_idx);
  end

  always_comb begin
    lvl_i = 4'sd0;
    lvl_q = 4'sd0;
    unique case (mode_eff)
      2'b00: lvl_i = bits[0] ? 4'sd1 : -4'sd1;
      2'b01: begin
        lvl_i = bits[0] ? 4'sd1 : -4'sd1;
        lvl_q = bits[1] ? 4'sd1 : -4'sd1;
      end
      2'b10: begin
        lvl_i = pam4(bits[0], bits[1]);
        lvl_q = pam4(bits[2], bits[3]);
      end
      default: begin
        lvl_i = pam8(bits[0], bits[1], bits[2]);
        lvl_q = pam8(bits[3], bits[4], bits[5]);
      end
    endcase
  end

  assign ext_i = {{(OUT_W-4){lvl_i[3]}}, lvl_i};
  assign ext_q = {{(OUT_W-4){lvl_q[3]}}, lvl_q};

`ifdef QAM_MAPPER_NORM_EN
  logic signed [OUT_W-1:0] scale;

  always_comb begin
    unique case (mode_eff)
      2'b00:   scale = OUT_W'(1024);
      2'b01:   scale = OUT_W'(724);
      2'b10:   scale = OUT_W'(324);
      default: scale = OUT_W'(158);
    endcase
  end

  // |7*158| = 1106 fits any OUT_W >= 12, so the product is exact
  assign smp_i = ext_i * scale;
  assign smp_q = ext_q * scale;
`else
  assign smp_i = ext_i;
  assign smp_q = ext_q;
`endif

  always_comb begin
    bcnt_d  = bcnt_eff;
    sr_d    = sr_eff;
    sc_d    = sc_eff;
    mode_d  = mode_q;
    valid_d = done;
    i_d     = i_q;
    q_d     = q_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (in_valid) begin
      mode_d = mode_eff;
      if (done) begin
        bcnt_d = 3'd0;
        sr_d   = 6'd0;
        sc_d   = (sc_eff == 6'd47) ? 6'd0 : sc_eff + 6'd1;
        i_d    = smp_i;
        q_d    = smp_q;
        idx_d  = sc_eff;
        last_d = (sc_eff == 6'd47);
      end else begin
        bcnt_d = bcnt_eff + 3'd1;
        sr_d   = bits;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q  <= 3'd0;
      sr_q    <= 6'd0;
      sc_q    <= 6'd0;
      mode_q  <= 2'b00;
      valid_q <= 1'b0;
      i_q     <= '0;
      q_q     <= '0;
      idx_q   <= 6'd0;
      last_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      sc_q    <= sc_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      i_q     <= i_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign out_i      = i_q;
  assign out_q      = q_q;
  assign out_valid  = valid_q;
  assign out_sc_idx = idx_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: directed vector table, corner sequences and
// randomized traffic checked against a queue-based constellation model.
module tb_qam_mapper;
  localparam int OUT_W = 12;

  logic clk = 1'b0;
  logic reset, sync, in, in_valid;
  logic [1:0] mode;
  logic signed [OUT_W-1:0] out_i, out_q;
  logic out_valid, out_last;
  logic [5:0] out_sc_idx;

  qam_mapper #(.OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sync(sync), .in(in), .in_valid(in_valid),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_sc_idx(out_sc_idx),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef QAM_MAPPER_NORM_EN
  int kt [4] = '{1024, 724, 324, 158};
`else
  int kt [4] = '{1, 1, 1, 1};
`endif
  int nbt [4] = '{1, 2, 4, 6};
  // Gray levels indexed by the bit group read first-bit-as-MSB
  int lv2 [4] = '{-3, -1, 3, 1};
  int lv3 [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

  // Reference model state
  int q_bits[$];
  int m_mode, m_sc;
  int exp_valid, exp_i, exp_q, exp_idx, exp_last;

  typedef struct {
    logic [1:0] m;
    int         nb;
    logic [5:0] bits;
    int         ei;
    int         eq;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int level(input int nbits, input int val);
    case (nbits)
      1:       return (val != 0) ? 1 : -1;
      2:       return lv2[val];
      default: return lv3[val];
    endcase
  endfunction

  function automatic void model_reset();
    q_bits.delete();
    m_mode = 0; m_sc = 0;
    exp_valid = 0; exp_i = 0; exp_q = 0; exp_idx = 0; exp_last = 0;
  endfunction

  function automatic void model_step(input int v, input int b, input int s, input int m);
    int half, vi, vq;
    exp_valid = 0;
    if (s != 0) begin
      q_bits.delete();
      m_sc = 0;
    end
    if (v != 0) begin
      if (q_bits.size() == 0) m_mode = m;
      q_bits.push_back(b);
      if (q_bits.size() == nbt[m_mode]) begin
        if (m_mode == 0) begin
          exp_i = level(1, q_bits[0]) * kt[0];
          exp_q = 0;
        end else begin
          half = nbt[m_mode] / 2;
          vi = 0; vq = 0;
          for (int j = 0; j < half; j++) begin
            vi = vi * 2 + q_bits[j];
            vq = vq * 2 + q_bits[half + j];
          end
          exp_i = level(half, vi) * kt[m_mode];
          exp_q = level(half, vq) * kt[m_mode];
        end
        exp_valid = 1;
        exp_idx   = m_sc;
        exp_last  = (m_sc == 47) ? 1 : 0;
        m_sc      = (m_sc + 1) % 48;
        q_bits.delete();
      end
    end
  endfunction

  task automatic check_outputs();
    check("out_valid", int'(out_valid), exp_valid);
    check("out_i", int'(out_i), exp_i);
    check("out_q", int'(out_q), exp_q);
    check("out_sc_idx", int'(out_sc_idx), exp_idx);
    check("out_last", int'(out_last), exp_last);
  endtask

  task automatic step(input logic v, input logic b, input logic s, input logic [1:0] m);
    @(negedge clk);
    in_valid = v; in = b; sync = s; mode = m;
    @(posedge clk);
    model_step(int'(v), int'(b), int'(s), int'(m));
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in = 1'b1; sync = 1'b0; mode = 2'b11;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_i", int'(out_i), 0);
      check("rst_q", int'(out_q), 0);
      check("rst_idx", int'(out_sc_idx), 0);
      check("rst_last", int'(out_last), 0);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] p64;
    reset = 1'b0; sync = 1'b0; in = 1'b0; in_valid = 1'b0; mode = 2'b00;
    vt[0] = '{2'b00, 1, 6'b000001,  1,  0};
    vt[1] = '{2'b00, 1, 6'b000000, -1,  0};
    vt[2] = '{2'b01, 2, 6'b000001,  1, -1};
    vt[3] = '{2'b10, 4, 6'b001001,  3, -1};
    vt[4] = '{2'b10, 4, 6'b001100, -3,  1};
    vt[5] = '{2'b11, 6, 6'b001110, -3,  7};
    vt[6] = '{2'b11, 6, 6'b110001,  7, -3};

    do_reset();

    // Directed vector table: each entry is one complete group
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vt[i].nb; j++) step(1'b1, vt[i].bits[j], 1'b0, vt[i].m);
      check("tbl_valid", int'(out_valid), 1);
      check("tbl_i", int'(out_i), vt[i].ei * kt[vt[i].m]);
      check("tbl_q", int'(out_q), vt[i].eq * kt[vt[i].m]);
    end

    // BPSK back-to-back, starting from a sync
    step(1'b1, 1'b1, 1'b1, 2'b00);
    check("bpsk0_valid", int'(out_valid), 1);
    check("bpsk0_idx", int'(out_sc_idx), 0);
    check("bpsk0_i", int'(out_i), kt[0]);
    step(1'b1, 1'b0, 1'b0, 2'b00);
    check("bpsk1_valid", int'(out_valid), 1);
    check("bpsk1_idx", int'(out_sc_idx), 1);
    check("bpsk1_i", int'(out_i), -kt[0]);
    check("bpsk1_q", int'(out_q), 0);

    // QPSK with gaps between the two bits
    step(1'b1, 1'b1, 1'b0, 2'b01);
    step(1'b0, 1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b01);
    check("qgap_novalid", int'(out_valid), 0);
    step(1'b1, 1'b0, 1'b0, 2'b01);
    check("qgap_valid", int'(out_valid), 1);
    check("qgap_i", int'(out_i), kt[1]);
    check("qgap_q", int'(out_q), -kt[1]);

    // 64-QAM full symbol: out_last only at idx 47, then wrap to 0
    step(1'b0, 1'b0, 1'b1, 2'b11);
    p64 = 6'b001110;
    for (int g = 0; g < 49; g++) begin
      for (int j = 0; j < 6; j++) step(1'b1, p64[j], 1'b0, 2'b11);
      check("sym_valid", int'(out_valid), 1);
      check("sym_idx", int'(out_sc_idx), g % 48);
      check("sym_last", int'(out_last), (g == 47) ? 1 : 0);
      check("sym_i", int'(out_i), -3 * kt[3]);
      check("sym_q", int'(out_q), 7 * kt[3]);
    end

    // Mid-group sync, then mode change with bcnt=1 ignored until next group
    step(1'b1, 1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 1'b1, 2'b01);
    check("msync_novalid", int'(out_valid), 0);
    step(1'b1, 1'b0, 1'b0, 2'b10);
    check("msync_valid", int'(out_valid), 1);
    check("msync_idx", int'(out_sc_idx), 0);
    check("msync_i", int'(out_i), -kt[1]);
    check("msync_q", int'(out_q), -kt[1]);
    step(1'b1, 1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 1'b0, 2'b01);
    check("m16_pending", int'(out_valid), 0);
    step(1'b1, 1'b1, 1'b0, 2'b01);
    check("m16_valid", int'(out_valid), 1);
    check("m16_idx", int'(out_sc_idx), 1);
    check("m16_i", int'(out_i), 3 * kt[2]);
    check("m16_q", int'(out_q), -kt[2]);

    // Reset mid-group discards the partial group
    step(1'b1, 1'b1, 1'b0, 2'b01);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 2'b01);
    check("rmid_novalid", int'(out_valid), 0);
    step(1'b1, 1'b1, 1'b0, 2'b01);
    check("rmid_valid", int'(out_valid), 1);
    check("rmid_idx", int'(out_sc_idx), 0);
    check("rmid_i", int'(out_i), kt[1]);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_mapper.md
# qam_mapper

Serial-to-constellation mapper for the 802.11a baseband transmit chain. It sits directly downstream of the interleaver and consumes the interleaver's serial bit stream one bit per valid cycle. It groups N_BPSC bits according to the selected modulation, applies the 802.11a Gray mapping, and emits one signed I/Q sample per data subcarrier. It also emits a subcarrier index (0..47) and a last-of-symbol flag for the IFFT/pilot-insertion stage.

## Interface
- OUT_W, 12, signed width of out_i/out_q; must be ≥ 12.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- mode  input  2  00 BPSK (N_BPSC=1), 01 QPSK (2), 10 16-QAM (4), 11 64-QAM (6).
- sync  input  1  synchronous clear of bit and subcarrier counters (start of frame).
- in  input  1  serial coded/interleaved bit.
- in_valid  input  1  in is consumed on a rising edge where in_valid=1.
- out_i  output  OUT_W  signed in-phase sample.
- out_q  output  OUT_W  signed quadrature sample.
- out_valid  output  1  one-cycle pulse, out_i/out_q/out_sc_idx/out_last are new.
- out_sc_idx  output  6  data subcarrier index 0..47 of the current sample.
- out_last  output  1  high together with out_valid when out_sc_idx=47.

## Operation
- Bit counter bcnt (0..5) and 6-bit shift register hold the partial group; bit b0 is the first bit received.
- Mode latch: mode is sampled into mode_q when a bit is accepted with bcnt=0; mode changes mid-group are ignored until the next group.
- When the accepted bit is bit N_BPSC-1 of mode_q, the group completes: the mapped sample is registered, bcnt returns to 0, and out_valid pulses.
- Gray mapping, levels in odd integers:
  - BPSK: b0 0→-1, 1→+1; Q=0.
  - QPSK: I from b0, Q from b1, 0→-1, 1→+1.
  - 16-QAM: I from b0b1, Q from b2b3: 00→-3, 01→-1, 11→+1, 10→+3.
  - 64-QAM: I from b0b1b2, Q from b3b4b5: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Subcarrier counter sc (0..47) is presented as out_sc_idx with each sample. It increments after each completed group and wraps 47→0. out_last=1 when the presented index is 47.
- sync: clears bcnt, the shift register and sc.
  - If in_valid=1 in the same cycle, that bit becomes b0 of a new group, and mode is latched on that edge.
- Idle: when in_valid=0, no state changes. Outputs hold their last values; out_valid=0.

## Timing
- Reset values: out_i=0, out_q=0, out_valid=0, out_sc_idx=0, out_last=0, bcnt=0, sc=0, mode_q=00.
- Latency: outputs are registered on the same edge that accepts the last bit of a group, and are visible the following cycle. Latency is 1 clock from the final bit.
- out_valid is exactly one cycle wide. Back-to-back BPSK bits produce out_valid high on consecutive cycles.
- No backpressure: the block always accepts in_valid.
- Reset asserted mid-group discards the partial group; no output is produced for it.

## Configuration
- QAM_MAPPER_NORM_EN defined: output = level × K, where K is selected by mode_q.
  - K values: BPSK 1024, QPSK 724, 16-QAM 324, 64-QAM 158 (round(2^10/√(1,2,10,42))).
  - Result is exact in OUT_W (max |7×158|=1106); format is Q(OUT_W-10).10.
- Undefined: output = raw odd-integer level, sign-extended to OUT_W. No multiplier is instantiated.

## Test plan
- Reset: hold reset, drive in_valid=1 → all outputs 0, no out_valid. Release reset → the first group starts at bcnt=0, sc=0.
- BPSK, norm off: bits 1,0 consecutive → out_valid two consecutive cycles, (I,Q)=(+1,0) then (-1,0), out_sc_idx 0 then 1.
- QPSK, norm on: bits 1,0 → single out_valid, I=+724, Q=-724. Gaps in in_valid between the two bits → same result, delayed accordingly.
- 16-QAM, norm on: bits 1,0,0,1 → I=+972, Q=-324. Norm off → I=+3, Q=-1.
- 64-QAM, norm on: 48 groups of 0,1,1,1,0,0 → each I=-474, Q=+1106. out_last only on the 48th sample (idx 47), then the next group has idx 0.
- Mid-group sync: QPSK, bit 1, then sync with in_valid=1 and bit 0, then bit 0 → one sample (-724,-724) at idx 0. The discarded bit produces no output. A mode change to 16-QAM while bcnt=1 has no effect until the next group.
